// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types and constants.
package lc3_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

endpackage

// File: rtl/lc3_cc_logic.sv
// NZP condition-code register with sign/zero decode, plus the registered
// branch-enable term. Kept separate so the PSR/interrupt logic can reuse it.
module lc3_cc_logic
  import lc3_pkg::CC_N;
  import lc3_pkg::CC_Z;
  import lc3_pkg::CC_P;
#(
  parameter int         DATA_W   = 16,
  parameter logic [2:0] CC_RESET = 3'b010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus,
  input  logic              ld_cc,
  input  logic              ld_ben,
  input  logic [2:0]        ir_nzp,
  output logic [2:0]        nzp,
  output logic              ben
);

  logic [2:0] nzp_q, nzp_d;
  logic       ben_q, ben_d;
  logic [2:0] bus_cc;

  always_comb begin
    if (bus[DATA_W-1])    bus_cc = CC_N;
    else if (bus == '0)   bus_cc = CC_Z;
    else                  bus_cc = CC_P;
  end

  // ben samples nzp_q, so a simultaneous CC load cannot affect this branch decision
  always_comb begin
    nzp_d = nzp_q;
    ben_d = ben_q;
    if (ld_cc)  nzp_d = bus_cc;
    if (ld_ben) ben_d = |(ir_nzp & nzp_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzp_q <= CC_RESET;
      ben_q <= 1'b0;
    end else begin
      nzp_q <= nzp_d;
      ben_q <= ben_d;
    end
  end

  assign nzp = nzp_q;
  assign ben = ben_q;

endmodule

// File: rtl/lc3_regfile.sv
// LC-3 general-purpose register file R0-R7 with two combinational read ports.
// Define LC3_REGFILE_BYPASS_EN for write-through forwarding on the read ports.
module lc3_regfile
  import lc3_pkg::reg_addr_t;
#(
  parameter int         DATA_W   = 16,
  parameter int         NREGS    = 8,
  parameter logic [2:0] CC_RESET = 3'b010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus,
  input  logic              ld_reg,
  input  reg_addr_t         dr,
  input  reg_addr_t         sr1,
  input  reg_addr_t         sr2,
  output logic [DATA_W-1:0] sr1_out,
  output logic [DATA_W-1:0] sr2_out,
  input  logic              ld_cc,
  input  logic              ld_ben,
  input  logic [2:0]        ir_nzp,
  output logic [2:0]        nzp,
  output logic              ben
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (ld_reg) regs_d[dr] = bus;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef LC3_REGFILE_BYPASS_EN
  assign sr1_out = (ld_reg && (sr1 == dr)) ? bus : regs_q[sr1];
  assign sr2_out = (ld_reg && (sr2 == dr)) ? bus : regs_q[sr2];
`else
  assign sr1_out = regs_q[sr1];
  assign sr2_out = regs_q[sr2];
`endif

  lc3_cc_logic #(
    .DATA_W   (DATA_W),
    .CC_RESET (CC_RESET)
  ) u_cc (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .ld_cc  (ld_cc),
    .ld_ben (ld_ben),
    .ir_nzp (ir_nzp),
    .nzp    (nzp),
    .ben    (ben)
  );

  a_dr_known: assert property (@(posedge clk) disable iff (!rst_n) ld_reg |-> !$isunknown(dr))
    else $error("lc3_regfile: unknown dr with ld_reg asserted");

endmodule

// File: tb/tb_lc3_regfile.sv
// Directed bench for lc3_regfile: stimulus pushes expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_lc3_regfile;

  localparam int KIND_SR1 = 0;
  localparam int KIND_SR2 = 1;
  localparam int KIND_NZP = 2;
  localparam int KIND_BEN = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] bus;
  logic        ld_reg;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] sr1_out;
  logic [15:0] sr2_out;
  logic        ld_cc;
  logic        ld_ben;
  logic [2:0]  ir_nzp;
  logic [2:0]  nzp;
  logic        ben;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  lc3_regfile dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .ld_reg  (ld_reg),
    .dr      (dr),
    .sr1     (sr1),
    .sr2     (sr2),
    .sr1_out (sr1_out),
    .sr2_out (sr2_out),
    .ld_cc   (ld_cc),
    .ld_ben  (ld_ben),
    .ir_nzp  (ir_nzp),
    .nzp     (nzp),
    .ben     (ben)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: everything queued since the last active edge is due at this negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        KIND_SR1: act = sr1_out;
        KIND_SR2: act = sr2_out;
        KIND_NZP: act = {13'd0, nzp};
        default:  act = {15'd0, ben};
      endcase
      n_checks++;
      if (act !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end else begin
        $display("check %s: %h ok", e.name, act);
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [15:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] same_cycle_exp;
    rst_n = 1'b0; bus = '0; ld_reg = 1'b0; dr = '0; sr1 = '0; sr2 = '0;
    ld_cc = 1'b0; ld_ben = 1'b0; ir_nzp = '0;

    // Power-on reset state
    cyc();
    expect_val("por_sr1", KIND_SR1, 16'h0000);
    expect_val("por_nzp", KIND_NZP, 16'h0002);
    expect_val("por_ben", KIND_BEN, 16'h0000);
    cyc();
    rst_n = 1'b1;

    // Test 1: write R3, then asynchronous reset mid-cycle, write during reset lost
    ld_reg = 1'b1; dr = 3'd3; bus = 16'h1234;
    cyc();
    ld_reg = 1'b0; sr1 = 3'd3;
    expect_val("r3_written", KIND_SR1, 16'h1234);
    cyc();
    ld_cc = 1'b1; bus = 16'h8000;
    cyc();
    ld_cc = 1'b0;
    expect_val("pre_rst_nzp", KIND_NZP, 16'h0004);
    cyc();
    rst_n = 1'b0;
    ld_reg = 1'b1; dr = 3'd3; bus = 16'hFFFF;
    expect_val("rst_async_sr1", KIND_SR1, 16'h0000);
    expect_val("rst_async_nzp", KIND_NZP, 16'h0002);
    expect_val("rst_async_ben", KIND_BEN, 16'h0000);
    cyc();
    rst_n = 1'b1; ld_reg = 1'b0;
    expect_val("rst_write_lost", KIND_SR1, 16'h0000);
    cyc();

    // Test 2: write/read on both ports, neighbour untouched
    ld_reg = 1'b1; dr = 3'd5; bus = 16'hBEEF;
    cyc();
    ld_reg = 1'b0; sr1 = 3'd5; sr2 = 3'd5;
    expect_val("r5_sr1", KIND_SR1, 16'hBEEF);
    expect_val("r5_sr2", KIND_SR2, 16'hBEEF);
    cyc();
    sr2 = 3'd4;
    expect_val("r4_untouched", KIND_SR2, 16'h0000);
    cyc();

    // Test 3: CC decode
    ld_cc = 1'b1; bus = 16'h8000;
    cyc();
    expect_val("cc_8000", KIND_NZP, 16'h0004);
    bus = 16'h0000;
    cyc();
    expect_val("cc_0000", KIND_NZP, 16'h0002);
    bus = 16'h7FFF;
    cyc();
    expect_val("cc_7fff", KIND_NZP, 16'h0001);
    bus = 16'hFFFF;
    cyc();
    expect_val("cc_ffff", KIND_NZP, 16'h0004);
    ld_cc = 1'b0; bus = 16'h0000;
    cyc();
    expect_val("cc_hold", KIND_NZP, 16'h0004);

    // Test 4: BEN uses pre-edge nzp
    ld_cc = 1'b1; bus = 16'h0001;
    cyc();
    expect_val("cc_p_setup", KIND_NZP, 16'h0001);
    bus = 16'h0000; ld_ben = 1'b1; ir_nzp = 3'b001;
    cyc();
    expect_val("ben_order_nzp", KIND_NZP, 16'h0002);
    expect_val("ben_order_old", KIND_BEN, 16'h0001);
    ld_cc = 1'b0;
    cyc();
    expect_val("ben_next_zero", KIND_BEN, 16'h0000);
    ir_nzp = 3'b010;
    cyc();
    expect_val("ben_z_match", KIND_BEN, 16'h0001);
    ld_ben = 1'b0; ir_nzp = 3'b000;
    cyc();
    expect_val("ben_hold", KIND_BEN, 16'h0001);

    // Test 5: same-cycle write/read
    ld_reg = 1'b1; dr = 3'd2; bus = 16'h0011;
    cyc();
    bus = 16'h00AA; sr1 = 3'd2;
`ifdef LC3_REGFILE_BYPASS_EN
    same_cycle_exp = 16'h00AA;
`else
    same_cycle_exp = 16'h0011;
`endif
    expect_val("same_cycle_before", KIND_SR1, same_cycle_exp);
    cyc();
    ld_reg = 1'b0;
    expect_val("same_cycle_after", KIND_SR1, 16'h00AA);
    cyc();

    // Test 6: back-to-back writes of every register, then all read pairs
    for (int i = 0; i < 8; i++) begin
      ld_reg = 1'b1; dr = 3'(i); bus = 16'h1000 + 16'(i);
      cyc();
    end
    ld_reg = 1'b0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        sr1 = 3'(a); sr2 = 3'(b);
        expect_val($sformatf("pair_sr1_%0d_%0d", a, b), KIND_SR1, 16'h1000 + 16'(a));
        expect_val($sformatf("pair_sr2_%0d_%0d", a, b), KIND_SR2, 16'h1000 + 16'(b));
        cyc();
      end
    end

    cyc();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lc3_regfile.md
Name: lc3_regfile

Overview:
- General-purpose register file, R0–R7, for the LC-3 datapath. Sits directly upstream of the ALU.
- Two combinational read ports (SR1 and SR2) drive the ALU operand inputs a and b.
- One synchronous write port loads a register from the 16-bit bus.
- Also holds the NZP condition-code register, loaded from the bus, and produces the branch-enable (BEN) term for the control FSM.

Parameters:
- DATA_W, 16, register and bus width.
- NREGS, 8, number of general-purpose registers; address width is clog2(NREGS) = 3.
- CC_RESET, 3'b010, NZP value loaded at reset (Z set).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus  input  DATA_W  shared datapath bus; write data for registers and the CC source.
- ld_reg  input  1  write enable for the register addressed by dr.
- dr  input  3  destination register address.
- sr1  input  3  read address, port 1.
- sr2  input  3  read address, port 2.
- sr1_out  output  DATA_W  contents of R[sr1]; drives ALU operand a.
- sr2_out  output  DATA_W  contents of R[sr2]; drives ALU operand b.
- ld_cc  input  1  load NZP from the bus value.
- ld_ben  input  1  load the BEN register.
- ir_nzp  input  3  IR[11:9], the branch condition mask.
- nzp  output  3  current condition codes, N at bit 2, Z at bit 1, P at bit 0.
- ben  output  1  registered branch enable.

Behaviour:
- Reset:
  - Asynchronous, active-low, single clock.
  - While rst_n=0: all R0–R7 = 0, nzp = CC_RESET, ben = 0, so sr1_out = sr2_out = 0.
  - Takes effect immediately, with no clock required.
  - Reset asserted mid-write: the write is lost and the register stays 0.
  - First write is accepted on the first rising edge after rst_n deasserts.
- Read ports:
  - Purely combinational, zero latency.
  - sr1_out = R[sr1], sr2_out = R[sr2].
  - Same address on both ports is legal; both outputs carry the same value.
- Write port:
  - On a rising edge with ld_reg=1, R[dr] <= bus.
  - Read outputs reflect the new value in the cycle after the edge (see Optional Feature for bypass).
  - ld_reg=0: all registers hold.
  - There is no hard-wired zero register; R0 is writable.
- Condition codes:
  - On a rising edge with ld_cc=1:
    - bus[15]=1 → nzp <= 100.
    - bus == 0 → nzp <= 010.
    - otherwise → nzp <= 001.
  - Exactly one bit is set after any load. Reset value 010 also satisfies this.
  - ld_cc=0: nzp holds.
- Branch enable:
  - On a rising edge with ld_ben=1, ben <= |(ir_nzp & nzp).
  - Uses nzp as it stood before that edge.
  - If ld_cc and ld_ben are asserted in the same cycle, ben uses the old nzp.
  - ld_ben=0: ben holds.
- Simultaneous events:
  - ld_reg, ld_cc and ld_ben are independent and may be asserted together.
  - All three updates occur on the same edge.
- Unknowns: X on dr with ld_reg=1 is a simulation assertion error. No defined hardware behaviour is required.

Optional Feature:
- Macro: LC3_REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding. When ld_reg=1 and sr1==dr, sr1_out = bus combinationally in the same cycle; likewise for sr2.
  - Registers still update on the edge.
- Undefined:
  - Read ports show only stored contents; a same-cycle write is visible from the next cycle only.
  - Default build leaves the macro undefined, because the multicycle FSM never reads a register in the cycle it is written.

Decomposition:
- Shared package lc3_pkg:
  - DATA_W = 16, REG_AW = 3.
  - Typedef reg_addr_t (3 bits), typedef word_t (16 bits).
  - NZP constants CC_N = 3'b100, CC_Z = 3'b010, CC_P = 3'b001.
- One sub-module, lc3_cc_logic:
  - Contains the nzp and ben registers plus the sign/zero decode.
  - Reusable by the PSR/interrupt logic.
- The register array and read muxes stay in lc3_regfile.

Test Plan:
1. Reset: write R3=16'h1234, pulse rst_n low between clock edges → sr1_out (sr1=3) = 16'h0000 immediately; nzp = 010; ben = 0.
2. Write/read: ld_reg=1, dr=5, bus=16'hBEEF, one edge; then sr1=5, sr2=5 → both outputs 16'hBEEF; R4 unchanged at 0.
3. CC decode:
   - ld_cc with bus=16'h8000 → nzp=100.
   - bus=16'h0000 → 010.
   - bus=16'h7FFF → 001.
   - Bus 16'hFFFF → 100.
4. BEN ordering: nzp=001, assert ld_cc (bus=16'h0000), ld_ben and ir_nzp=001 together → after the edge nzp=010, ben=1 (old nzp used). Next cycle ld_ben with ir_nzp=001 → ben=0.
5. Same-cycle write/read: ld_reg=1, dr=2, bus=16'h00AA, sr1=2, R2 previously 16'h0011 → before the edge sr1_out = 16'h0011 (bypass off) or 16'h00AA (LC3_REGFILE_BYPASS_EN); after the edge 16'h00AA in both builds.
6. Back-to-back writes to all 8 registers with bus = 16'h1000+i, then read every pair (sr1, sr2) → each port returns 16'h1000+addr.
